vga_timing: RTL and testbench
=============================

Name: vga_timing

Overview:
- Pixel-clock timing generator for the Mini8086 VGA path; sits directly upstream of the VGA register/colour block.
- Produces the active-low hsync/vsync that the register block samples for its status bits and vsync IRQ.
- Produces the blanking and character-cell coordinates used by the pixel fetch logic.
- Latches the display mode/plane from the register block only at frame boundaries, so a mid-frame write never tears the picture.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CHAR_W, 8, glyph width in pixels (power of two)
- CHAR_H, 16, glyph height in lines (power of two)

Ports:
- clk  in  1  pixel clock, 25.175 MHz
- reset  in  1  synchronous, active-high reset
- mode_in  in  2  display mode from register block
- plane_in  in  1  plane select from register block
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- blank  out  1  1 outside the visible area
- hcount  out  10  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- char_col  out  7  hcount/CHAR_W, valid while blank=0
- char_row  out  5  vcount/CHAR_H, valid while blank=0
- glyph_x  out  3  hcount mod CHAR_W
- glyph_y  out  4  vcount mod CHAR_H
- frame_start  out  1  one-cycle pulse at hcount=0, vcount=0
- line_start  out  1  one-cycle pulse at every hcount=0
- mode  out  2  frame-latched mode
- plane  out  1  frame-latched plane

Behaviour:
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (525).
- Counters: hcount increments every clk.
  - At H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - vcount wraps from V_TOTAL-1 to 0 on the same edge that hcount wraps.
- Output alignment: all outputs are registered, computed from next-counter values. In any cycle, every output describes the hcount/vcount values presented in that same cycle; there is no skew between hcount and hsync/blank.
- hsync = 0 iff H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- vsync = 0 iff V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC (490..491). vsync is a function of vcount only, so it changes at hcount=0.
- blank = 1 iff hcount >= H_VISIBLE or vcount >= V_VISIBLE.
- char_col, char_row, glyph_x, glyph_y are the bit-slices of hcount/vcount; they are not masked during blank (consumers gate them with blank).
- line_start = 1 iff hcount=0. frame_start = 1 iff hcount=0 and vcount=0.
- Mode latch:
  - mode and plane load mode_in and plane_in on the edge that produces frame_start=1.
  - Otherwise they hold, regardless of mode_in changes.
  - A change at hcount=H_TOTAL-1, vcount=V_TOTAL-1 is captured into the new frame.
- Reset (synchronous, priority over counting):
  - hcount=0, vcount=0, hsync=1, vsync=1, blank=0.
  - char_col/char_row/glyph_x/glyph_y=0, line_start=1, frame_start=1.
  - mode=2'b00, plane=0; mode_in is not sampled during reset.
  - The first cycle after reset deassertion is hcount=1.
- Reset mid-frame: counters return to 0 on the next edge with no partial sync pulse extension. A vsync low in progress goes high on that edge.
- No illegal states: counters only take values 0..TOTAL-1. Any value >= TOTAL (e.g. after a glitch) wraps to 0 on the next increment.

Test Plan:
- Reset: hold reset 3 clocks, release -> cycle after release hcount=1, vcount=0; during reset hsync=1, vsync=1, blank=0, frame_start=1, mode=0.
- Horizontal timing: run one line -> hsync low exactly at hcount 656..751 (96 cycles); blank rises at hcount=640; line_start period = 800 clocks.
- Vertical timing: run one full frame (420000 clocks) -> vsync low for exactly 1600 clocks starting at vcount=490, hcount=0; frame_start period = 420000; vcount never exceeds 524.
- Char coordinates: at hcount=637, vcount=479 -> char_col=79, glyph_x=5, char_row=29, glyph_y=15, blank=0; next cycle at hcount=640 -> blank=1.
- Mode latch: set mode_in=2, plane_in=1 at vcount=100 -> mode/plane unchanged until next frame_start, then mode=2, plane=1; change mode_in at hcount=799, vcount=524 -> captured on the immediate frame_start.
- Reset mid-operation: assert reset at vcount=491, hcount=300 (vsync low) -> next edge vsync=1, hcount=0, vcount=0, mode=0.

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing -- pixel-clock timing generator for the VGA path.
//
// Generates the horizontal/vertical counters, active-low syncs, blanking,
// character-cell coordinates and line/frame pulses for a raster display.
// The display mode and plane from the register block are sampled only on
// the edge that starts a new frame, so a mid-frame write never tears.
//
// Every output is a register loaded from the *next* counter values, so in
// any cycle all outputs describe the hcount/vcount shown in that cycle.
//
// Ports:
//   clk         in   pixel clock
//   reset       in   synchronous, active-high reset
//   mode_in     in   [1:0] display mode from register block
//   plane_in    in   plane select from register block
//   hsync       out  horizontal sync, active low
//   vsync       out  vertical sync, active low
//   blank       out  1 outside the visible area
//   hcount      out  [9:0] pixel column, 0..H_TOTAL-1
//   vcount      out  [9:0] line, 0..V_TOTAL-1
//   char_col    out  [6:0] hcount / CHAR_W
//   char_row    out  [4:0] vcount / CHAR_H
//   glyph_x     out  [2:0] hcount mod CHAR_W
//   glyph_y     out  [3:0] vcount mod CHAR_H
//   frame_start out  pulse at hcount=0, vcount=0
//   line_start  out  pulse at every hcount=0
//   mode        out  [1:0] frame-latched mode
//   plane       out  frame-latched plane

module vga_timing #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CHAR_W    = 8,
  parameter int unsigned CHAR_H    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode_in,
  input  logic       plane_in,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic [6:0] char_col,
  output logic [4:0] char_row,
  output logic [2:0] glyph_x,
  output logic [3:0] glyph_y,
  output logic       frame_start,
  output logic       line_start,
  output logic [1:0] mode,
  output logic       plane
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Glyph sizes are powers of two, so cell coordinates are plain bit-slices.
  localparam int unsigned CW_SH   = $clog2(CHAR_W);
  localparam int unsigned CH_SH   = $clog2(CHAR_H);
  localparam logic [9:0]  GX_MASK = 10'(CHAR_W - 1);
  localparam logic [9:0]  GY_MASK = 10'(CHAR_H - 1);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       blank_q, blank_d;
  logic [6:0] char_col_q, char_col_d;
  logic [4:0] char_row_q, char_row_d;
  logic [2:0] glyph_x_q, glyph_x_d;
  logic [3:0] glyph_y_q, glyph_y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [1:0] mode_q, mode_d;
  logic       plane_q, plane_d;

  logic       h_wrap;

  always_comb begin
    // NOTE: every variable gets a value before any conditional update, so
    // no path through this block leaves one unassigned (no latch inferred).
    h_wrap   = (hcount_q >= H_LAST);  // >= also recovers out-of-range values
    hcount_d = h_wrap ? '0 : hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = (vcount_q >= V_LAST) ? '0 : vcount_q + 10'd1;
    end

    hsync_d = !((hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END));
    vsync_d = !((vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END));
    blank_d = (hcount_d >= H_VIS) || (vcount_d >= V_VIS);

    // Not masked during blanking; consumers gate with blank.
    char_col_d = 7'(hcount_d >> CW_SH);
    char_row_d = 5'(vcount_d >> CH_SH);
    glyph_x_d  = 3'(hcount_d & GX_MASK);
    glyph_y_d  = 4'(vcount_d & GY_MASK);

    line_start_d  = (hcount_d == '0);
    frame_start_d = line_start_d && (vcount_d == '0);

    // Load on the edge that raises frame_start; a write in the final cycle
    // of the previous frame therefore lands in the new frame.
    mode_d  = frame_start_d ? mode_in  : mode_q;
    plane_d = frame_start_d ? plane_in : plane_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b0;
      char_col_q    <= '0;
      char_row_q    <= '0;
      glyph_x_q     <= '0;
      glyph_y_q     <= '0;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
      mode_q        <= 2'b00;
      plane_q       <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      char_col_q    <= char_col_d;
      char_row_q    <= char_row_d;
      glyph_x_q     <= glyph_x_d;
      glyph_y_q     <= glyph_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      mode_q        <= mode_d;
      plane_q       <= plane_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank       = blank_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign char_col    = char_col_q;
  assign char_row    = char_row_q;
  assign glyph_x     = glyph_x_q;
  assign glyph_y     = glyph_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign mode        = mode_q;
  assign plane       = plane_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing. Horizontal geometry is the standard
// 640/16/96/48; the vertical geometry is shortened to 16/1/2/1 (20 lines,
// 16000 clocks per frame) so several frame boundaries fit in a short run.
// Vertical expectations: vsync low on lines 17..18, vcount max 19.

module tb_vga_timing;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode_in;
  logic       plane_in;
  logic       hsync, vsync, blank;
  logic [9:0] hcount, vcount;
  logic [6:0] char_col;
  logic [4:0] char_row;
  logic [2:0] glyph_x;
  logic [3:0] glyph_y;
  logic       frame_start, line_start;
  logic [1:0] mode;
  logic       plane;

  int tests = 0;
  int fails = 0;

  // line / frame measurement scratch
  int hs_cnt, hs_first, hs_last, bl_cnt, bl_first, ls_cnt;
  int since_fs, vs_cnt, vs_first_h, vs_first_v, vmax, mode_bad, n;
  bit fs_seen;

  vga_timing #(
    .V_VISIBLE(16), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut (
    .clk(clk), .reset(reset), .mode_in(mode_in), .plane_in(plane_in),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .hcount(hcount), .vcount(vcount),
    .char_col(char_col), .char_row(char_row),
    .glyph_x(glyph_x), .glyph_y(glyph_y),
    .frame_start(frame_start), .line_start(line_start),
    .mode(mode), .plane(plane)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hv(input int h, input int v, input int budget);
    int k = 0;
    while (!(hcount == 10'(h) && vcount == 10'(v)) && k < budget) begin
      step();
      k++;
    end
    check("wait_hv", {hcount, vcount}, {10'(h), 10'(v)});
  endtask

  initial begin
    // ---- reset held 3 clocks; mode_in must not be sampled ----
    reset = 1'b1; mode_in = 2'd3; plane_in = 1'b1;
    repeat (3) step();
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_blank", blank, 0);
    check("rst_frame_start", frame_start, 1);
    check("rst_line_start", line_start, 1);
    check("rst_mode", mode, 0);
    check("rst_plane", plane, 0);

    reset = 1'b0; mode_in = 2'd0; plane_in = 1'b0;
    step();
    check("rel_hcount", hcount, 1);
    check("rel_vcount", vcount, 0);
    check("rel_frame_start", frame_start, 0);
    check("rel_line_start", line_start, 0);

    // ---- one line: hcount 2..799 then 0 ----
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    bl_cnt = 0; bl_first = -1; ls_cnt = 0;
    repeat (799) begin
      step();
      if (!hsync) begin
        if (hs_cnt == 0) hs_first = int'(hcount);
        hs_last = int'(hcount);
        hs_cnt++;
      end
      if (blank) begin
        if (bl_first < 0) bl_first = int'(hcount);
        bl_cnt++;
      end
      if (line_start) ls_cnt++;
    end
    check("hsync_first", hs_first, 656);
    check("hsync_last", hs_last, 751);
    check("hsync_width", hs_cnt, 96);
    check("blank_first", bl_first, 640);
    check("blank_width", bl_cnt, 160);
    check("line_start_count", ls_cnt, 1);
    check("line_wrap_hcount", hcount, 0);
    check("line_wrap_vcount", vcount, 1);
    check("line_start_pulse", line_start, 1);

    // ---- rest of frame 0: vsync, frame period, char coords, mode hold ----
    since_fs = 800; vs_cnt = 0; vs_first_h = -1; vs_first_v = -1;
    vmax = 0; mode_bad = 0; fs_seen = 1'b0; n = 0;
    while (!fs_seen && n < 20000) begin
      step();
      n++;
      since_fs++;
      fs_seen = frame_start;
      if (!vsync) begin
        if (vs_cnt == 0) begin
          vs_first_h = int'(hcount);
          vs_first_v = int'(vcount);
        end
        vs_cnt++;
      end
      if (int'(vcount) > vmax) vmax = int'(vcount);
      if (!frame_start && (mode != 2'd0 || plane != 1'b0)) mode_bad++;
      if (hcount == 10'd0 && vcount == 10'd10) begin
        mode_in = 2'd2; plane_in = 1'b1;
      end
      if (hcount == 10'd637 && vcount == 10'd15) begin
        check("cc_char_col", char_col, 79);
        check("cc_glyph_x", glyph_x, 5);
        check("cc_char_row", char_row, 0);
        check("cc_glyph_y", glyph_y, 15);
        check("cc_blank", blank, 0);
      end
      if (hcount == 10'd5 && vcount == 10'd19) begin
        check("vb_char_row", char_row, 1);
        check("vb_glyph_y", glyph_y, 3);
        check("vb_glyph_x", glyph_x, 5);
        check("vb_blank", blank, 1);
      end
    end
    check("frame_start_seen", fs_seen, 1);
    check("frame_period", since_fs, 16000);
    check("vsync_low_clocks", vs_cnt, 1600);
    check("vsync_first_h", vs_first_h, 0);
    check("vsync_first_v", vs_first_v, 17);
    check("vcount_max", vmax, 19);
    check("mode_held_midframe", mode_bad, 0);
    check("frame_hcount", hcount, 0);
    check("frame_vcount", vcount, 0);
    check("latched_mode", mode, 2);
    check("latched_plane", plane, 1);

    // ---- frame 1: change in the very last cycle is captured ----
    wait_hv(798, 19, 17000);
    check("late_mode_before", mode, 2);
    step();
    check("late_frame_start_pre", frame_start, 0);
    mode_in = 2'd3; plane_in = 1'b0;
    step();
    check("late_frame_start", frame_start, 1);
    check("late_mode", mode, 3);
    check("late_plane", plane, 0);

    // ---- frame 2: reset during vsync low ----
    wait_hv(300, 18, 17000);
    check("midrst_vsync_pre", vsync, 0);
    reset = 1'b1;
    step();
    check("midrst_vsync", vsync, 1);
    check("midrst_hcount", hcount, 0);
    check("midrst_vcount", vcount, 0);
    check("midrst_mode", mode, 0);
    check("midrst_plane", plane, 0);
    check("midrst_blank", blank, 0);
    reset = 1'b0;
    step();
    check("midrst_rel_hcount", hcount, 1);
    check("midrst_rel_vcount", vcount, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
